// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle RV32M multiply/divide sequencer
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    input  logic [4:0]      req_rd_addr_i,
    output logic            ready_o,
    input  logic            flush_i,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      result_rd_addr_o,
    input  logic            mem_ready_i,
    output logic            busy_o
);

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    // hi_q: upper product half / partial remainder; lo_q: multiplier then
    // lower product half, or dividend then quotient; opb_q: multiplicand
    // for multiply, divisor for divide.
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   a_orig_q;
    logic              neg_q;
    logic              div_zero_q;
    logic [5:0]        count_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        result_rd_q;

    logic              a_signed_d;
    logic              b_signed_d;
    logic              sa_d;
    logic              sb_d;
    logic [XLEN-1:0]   a_abs_d;
    logic [XLEN-1:0]   b_abs_d;
    logic              neg_d;

    logic [XLEN:0]     mul_sum_d;
    logic [XLEN:0]     div_shift_d;
    logic [XLEN:0]     div_diff_d;
    logic [XLEN-1:0]   hi_d;
    logic [XLEN-1:0]   lo_d;

    logic [2*XLEN-1:0] prod_d;
    logic [2*XLEN-1:0] prod_fix_d;
    logic [XLEN-1:0]   quot_fix_d;
    logic [XLEN-1:0]   rem_fix_d;
    logic [XLEN-1:0]   result_d;

    // Operand sign handling at accept: magnitudes and the final result sign
    always_comb begin
        a_signed_d = 1'b0;
        b_signed_d = 1'b0;
        case (req_funct3_i)
            F_MULH, F_DIV, F_REM: begin
                a_signed_d = 1'b1;
                b_signed_d = 1'b1;
            end
            F_MULHSU: a_signed_d = 1'b1;
            default: ;
        endcase
        sa_d    = a_signed_d & req_rs1_i[XLEN-1];
        sb_d    = b_signed_d & req_rs2_i[XLEN-1];
        a_abs_d = sa_d ? ({XLEN{1'b0}} - req_rs1_i) : req_rs1_i;
        b_abs_d = sb_d ? ({XLEN{1'b0}} - req_rs2_i) : req_rs2_i;
        // remainder takes the dividend sign; product and quotient take sA^sB
        neg_d   = (req_funct3_i == F_REM) ? sa_d : (sa_d ^ sb_d);
    end

    // One shift-add multiply step or one restoring-divide step
    always_comb begin
        mul_sum_d   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        div_shift_d = {hi_q, lo_q[XLEN-1]};
        div_diff_d  = div_shift_d - {1'b0, opb_q};
        if (funct3_q[2]) begin
            // partial remainder is always below the divisor, so the
            // shifted value fits 33 bits and bit 32 of the difference
            // is a clean borrow flag
            if (!div_diff_d[XLEN]) begin
                hi_d = div_diff_d[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_shift_d[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum_d[XLEN:1];
            lo_d = {mul_sum_d[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign post-correction, word selection and divide-by-zero override
    always_comb begin
        prod_d     = {hi_q, lo_q};
        prod_fix_d = neg_q ? ({(2*XLEN){1'b0}} - prod_d) : prod_d;
        quot_fix_d = neg_q ? ({XLEN{1'b0}} - lo_q) : lo_q;
        rem_fix_d  = neg_q ? ({XLEN{1'b0}} - hi_q) : hi_q;
        case (funct3_q)
            F_MUL:                     result_d = prod_fix_d[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: result_d = prod_fix_d[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:             result_d = div_zero_q ? {XLEN{1'b1}} : quot_fix_d;
            F_REM, F_REMU:             result_d = div_zero_q ? a_orig_q : rem_fix_d;
            default:                   result_d = {XLEN{1'b0}};
        endcase
    end

    // Control FSM with datapath registers; flush overrides every state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            funct3_q    <= 3'd0;
            rd_q        <= 5'd0;
            hi_q        <= {XLEN{1'b0}};
            lo_q        <= {XLEN{1'b0}};
            opb_q       <= {XLEN{1'b0}};
            a_orig_q    <= {XLEN{1'b0}};
            neg_q       <= 1'b0;
            div_zero_q  <= 1'b0;
            count_q     <= 6'd0;
            result_q    <= {XLEN{1'b0}};
            result_rd_q <= 5'd0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            count_q <= 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        funct3_q   <= req_funct3_i;
                        rd_q       <= req_rd_addr_i;
                        a_orig_q   <= req_rs1_i;
                        neg_q      <= neg_d;
                        div_zero_q <= (req_rs2_i == {XLEN{1'b0}});
                        hi_q       <= {XLEN{1'b0}};
                        count_q    <= 6'd0;
                        if (req_funct3_i[2]) begin
                            lo_q  <= a_abs_d;
                            opb_q <= b_abs_d;
                        end else begin
                            lo_q  <= b_abs_d;
                            opb_q <= a_abs_d;
                        end
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    count_q <= count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q    <= result_d;
                    result_rd_q <= rd_q;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (mem_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready_o          = (state_q == S_IDLE);
    assign busy_o           = (state_q != S_IDLE);
    assign result_valid_o   = (state_q == S_DONE);
    assign result_o         = result_q;
    assign result_rd_addr_o = result_rd_q;

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for RV32M multiply/divide operations issued from the execute stage. It accepts one operation from decode and runs a 32-iteration shift-add multiply or restoring divide, with sign pre- and post-correction. It holds the result until the memory stage accepts it. While busy it deasserts `ready_o`, which the execute stage ANDs into `decode_ready_o` to stall the front of the pipeline.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported and verified.

Ports:
- `clk_i` in 1: single clock, all state updates on rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: decode presents an M-extension operation.
- `req_funct3_i` in 3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `req_rs1_i` in 32: operand A (dividend/multiplicand).
- `req_rs2_i` in 32: operand B (divisor/multiplier).
- `req_rd_addr_i` in 5: destination register.
- `ready_o` out 1: request accepted this cycle if `req_valid_i`; high only in IDLE.
- `flush_i` in 1: branch/jump flush from execute; aborts any operation.
- `result_valid_o` out 1: result held for memory stage.
- `result_o` out 32: final result.
- `result_rd_addr_o` out 5: destination of `result_o`.
- `mem_ready_i` in 1: memory stage accepts result this cycle.
- `busy_o` out 1: state is not IDLE (for hazard/monitor use).

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - `ready_o`=1.
  - On `req_valid_i && !flush_i`: latch funct3 and rd, and take absolute values of signed operands (DIV/REM: both; MULH: both; MULHSU: A only).
  - Record result sign: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - Clear the 6-bit iteration counter, then go to BUSY.
- BUSY, one iteration per cycle, counter 0..31:
  - Multiply: 64-bit accumulator; if multiplier LSB then add multiplicand into the upper half, then shift right 1.
  - Divide: shift {rem,quot} left 1; trial-subtract divisor from the 33-bit remainder; if non-negative, keep the difference and set quotient LSB.
  - Go to FIX after counter==31.
- FIX, one cycle:
  - Apply two's-complement negation per the recorded sign (64-bit for multiply).
  - Select low word for MUL and high word for MULH/MULHSU/MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
  - Divide-by-zero (B==0) override: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = original A.
  - Overflow (DIV of 0x80000000 by 0xFFFFFFFF) yields 0x80000000 and REM 0 naturally; no special case.
  - Register into `result_o` and go to DONE.
- DONE:
  - `result_valid_o`=1; `result_o` and `result_rd_addr_o` are stable.
  - On `mem_ready_i` go to IDLE.
- `flush_i` has priority in every state: the next state is IDLE and `result_valid_o` drops next cycle.
  - A result flushed in the same cycle as `mem_ready_i` is treated as not transferred; the memory stage must qualify with `!flush_i`.
- No request is accepted in the cycle DONE hands off; `ready_o` rises the following cycle.

## Timing
- Reset: state IDLE, counter 0, `result_valid_o`=0, `result_o`=0, `result_rd_addr_o`=0, `busy_o`=0. `ready_o` is decoded from state, so it is 1 in the first cycle after reset. Reset mid-operation discards all state.
- Latency, fixed and data-independent: accept at the edge ending cycle t; BUSY for cycles t+1..t+32; FIX at t+33; `result_valid_o` high from t+34.
- Back-to-back issue rate is 1 op per 35 cycles with `mem_ready_i` held high.
- `ready_o`, `busy_o` and `result_valid_o` are pure functions of state. No combinational path exists from `req_*` to any output.
- `result_o` changes only on the FIX→DONE transition.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `result_o`=0xFFFFFFEB at t+34; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. DIVU 5/0 → 0xFFFFFFFF, REMU 5/0 → 5, DIV −5/0 → 0xFFFFFFFF.
- Hold `mem_ready_i`=0 for 10 cycles in DONE → `result_valid_o` and data stable. Then pulse `mem_ready_i` → IDLE next cycle, and `ready_o`=1 one cycle later; `req_valid_i` during BUSY is ignored.
- `flush_i` at BUSY iteration 10, and separately in DONE together with `mem_ready_i` → IDLE next cycle, `result_valid_o`=0, no result delivered. A new MUL 3×4 then yields 12 at full latency.
- `rst_i` asserted for 1 cycle at BUSY iteration 20 → all outputs at reset values next cycle, `ready_o`=1.
